dly_cmd_table: RTL and testbench
================================

# dly_cmd_table

Register-domain source of the per-channel delay command bus consumed by the de-dispersion block. A host writes channel delay words one at a time into a shadow table, then issues a commit. The commit copies the whole table atomically onto the flat `cmd_ch_dly` bus and holds it stable for a guaranteed minimum period. That hold lets the multi-flop capture in `clk_data` always sample a settled value.

## Interface
- `CMD_WIDTH`, 32: width of one channel delay word.
- `NOF_CHANNEL`, 128: total channels; the table holds NOF_CHANNEL/2 entries (64).
- `ADDR_WIDTH`, 6: clog2(NOF_CHANNEL/2).
- `MAX_DELAY`, 4095: largest legal delay; larger writes are clamped to this value.
- `HOLD_CYCLES`, 16: minimum clk_reg cycles the bus stays frozen after an update; must be ≥ 2.

Ports:
- `clk_reg`  in  1  register clock; all logic in this domain.
- `rst`  in  1  reset; synchronous, active-high.
- `wr_en`  in  1  write strobe; takes effect only when `wr_ready`=1.
- `wr_addr`  in  ADDR_WIDTH  shadow entry index.
- `wr_data`  in  CMD_WIDTH  delay value.
- `wr_ready`  out  1  shadow accepts writes.
- `commit`  in  1  single-cycle request to publish the shadow table.
- `commit_done`  out  1  one-cycle pulse when a publish's hold period ends.
- `busy`  out  1  a publish is in progress or pending.
- `rd_sel`  in  1  readback source: 0 = shadow, 1 = active.
- `rd_addr`  in  ADDR_WIDTH  readback index.
- `rd_data`  out  CMD_WIDTH  registered readback.
- `err_range`  out  1  sticky flag: at least one write was clamped.
- `err_clr`  in  1  clears `err_range`.
- `cmd_ch_dly`  out  CMD_WIDTH*NOF_CHANNEL/2  active table; entry m occupies bits [m*CMD_WIDTH +: CMD_WIDTH].

## Operation
- Reset values:
  - shadow and active tables: all 0.
  - `cmd_ch_dly` 0, `rd_data` 0.
  - `commit_done` 0, `busy` 0, `err_range` 0, `pending` 0.
  - `wr_ready` 1; FSM in IDLE.
- Write path: on an accepted write, `shadow[wr_addr] <= min(wr_data, MAX_DELAY)`. The comparison is unsigned. A clamped write sets `err_range`.
- `err_clr` and a clamping write in the same cycle: set wins.
- FSM states:
  - IDLE: `commit` → APPLY.
  - APPLY (exactly 1 cycle): active <= shadow (all entries at once); cnt <= HOLD_CYCLES-1; → HOLD. `wr_ready`=0 in this state only.
  - HOLD: cnt decrements each cycle. When cnt==0, pulse `commit_done` and go to APPLY if `pending`=1 (clearing `pending`), otherwise to IDLE.
- A commit received in APPLY or HOLD sets `pending`. Multiple commits collapse into one.
- Writes are accepted in IDLE and HOLD. Writes made during HOLD reach the bus only on the next APPLY.
- `busy` = (state != IDLE) | pending.
- `cmd_ch_dly` is driven directly from the active-table flops, with no combinational path from any input.
- Readback: `rd_data <= rd_sel ? active[rd_addr] : shadow[rd_addr]`. Reads never stall.
- A reset asserted mid-publish aborts it: the bus returns to 0 and any pending commit is discarded.

## Timing
- Write latency: a write accepted at edge t is visible in shadow readback at rd_data edge t+1.
- A write and a `commit` in the same IDLE cycle: the write is included in the publish.
- Commit latency: `commit` sampled at edge t in IDLE → APPLY during cycle t..t+1 → `cmd_ch_dly` updates at edge t+1.
- The FSM is in HOLD for exactly HOLD_CYCLES cycles.
- `commit_done` is high for the cycle following edge t+1+HOLD_CYCLES.
- Minimum spacing between bus updates is HOLD_CYCLES+1 clk_reg cycles. Integrators choose HOLD_CYCLES so that this spacing exceeds 3 clk_data periods plus margin.
- `rd_data` latency: 1 cycle.

## Test plan
- Reset: after `rst`, `cmd_ch_dly`=0, `wr_ready`=1, `busy`=0; reading both tables at every address returns 0.
- Basic publish:
  - Stimulus: write addr 0 = 10 and addr 63 = 4095; pulse commit at edge t.
  - Required: bits [31:0]=10 and bits [2047:2016]=4095 at edge t+1; bus unchanged before edge t+1; `commit_done` pulses once, at edge t+17 (HOLD_CYCLES=16).
- Clamp: write addr 5 = 5000.
  - Required: shadow readback of addr 5 = 4095; `err_range`=1.
  - `err_clr` with no write clears the flag; `err_clr` together with another clamping write leaves it at 1.
- Hold/pending:
  - Stimulus: during HOLD, write addr 1 = 7 and pulse commit three times.
  - Required: bus holds its old value until HOLD ends; exactly one extra APPLY follows immediately; addr 1 then reads 7 on the bus; total of 2 `commit_done` pulses; update spacing ≥ 17 cycles.
- Write/commit collision: `wr_en` asserted during APPLY is ignored (`wr_ready`=0), so shadow is unchanged. A write and a commit in the same IDLE cycle are included in the publish.
- Mid-operation reset: `rst` asserted in HOLD with `pending`=1. Required: bus returns to 0, no `commit_done`, FSM is IDLE and stays idle with no further APPLY.

Source files
------------

// File: rtl/dly_cmd_table.sv
// Shadow/active delay command table: host writes a shadow copy; commit publishes it atomically onto cmd_ch_dly.
// Bus updates one cycle after commit and stays frozen HOLD_CYCLES cycles; writes stall only in APPLY, reads never stall.
module dly_cmd_table #(
    parameter int CMD_WIDTH   = 32,
    parameter int NOF_CHANNEL = 128,
    parameter int ADDR_WIDTH  = 6,
    parameter int MAX_DELAY   = 4095,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                                 clk_reg,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [ADDR_WIDTH-1:0]                wr_addr,
    input  logic [CMD_WIDTH-1:0]                 wr_data,
    output logic                                 wr_ready,
    input  logic                                 commit,
    output logic                                 commit_done,
    output logic                                 busy,
    input  logic                                 rd_sel,
    input  logic [ADDR_WIDTH-1:0]                rd_addr,
    output logic [CMD_WIDTH-1:0]                 rd_data,
    output logic                                 err_range,
    input  logic                                 err_clr,
    output logic [CMD_WIDTH*NOF_CHANNEL/2-1:0]   cmd_ch_dly
);

    localparam int DEPTH = NOF_CHANNEL / 2;
    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CMD_WIDTH-1:0] MAX_VAL = CMD_WIDTH'(MAX_DELAY);

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_HOLD} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pending_q, pending_d;
    logic                   commit_done_q, commit_done_d;
    logic                   busy_q, busy_d;
    logic                   wr_ready_q, wr_ready_d;
    logic                   err_range_q, err_range_d;
    logic [CMD_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [CMD_WIDTH-1:0]   shadow_q [DEPTH];
    logic [CMD_WIDTH-1:0]   shadow_d [DEPTH];
    logic [CMD_WIDTH-1:0]   active_q [DEPTH];
    logic [CMD_WIDTH-1:0]   active_d [DEPTH];

    logic                   wr_acc;
    logic                   wr_clamp;
    logic [CMD_WIDTH-1:0]   wr_val;

    always_comb begin
        wr_acc   = wr_en & wr_ready_q;
        wr_clamp = (wr_data > MAX_VAL);
        wr_val   = wr_clamp ? MAX_VAL : wr_data;

        shadow_d = shadow_q;
        if (wr_acc) begin
            shadow_d[wr_addr] = wr_val;
        end

        active_d      = active_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        pending_d     = pending_q;
        commit_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (commit || pending_q) begin
                    state_d   = S_APPLY;
                    pending_d = 1'b0;
                end
            end
            S_APPLY: begin
                active_d = shadow_q;
                cnt_d    = CNT_W'(HOLD_CYCLES - 1);
                state_d  = S_HOLD;
                if (commit) pending_d = 1'b1;
            end
            S_HOLD: begin
                if (commit) pending_d = 1'b1;
                if (cnt_q == '0) begin
                    commit_done_d = 1'b1;
                    // A commit arriving in the final hold cycle still chains straight into APPLY.
                    if (pending_d) begin
                        state_d   = S_APPLY;
                        pending_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ready_d = (state_d != S_APPLY);
        busy_d     = (state_d != S_IDLE) | pending_d;

        // Set beats clear when both land together.
        err_range_d = err_clr ? 1'b0 : err_range_q;
        if (wr_acc && wr_clamp) err_range_d = 1'b1;

        rd_data_d = rd_sel ? active_q[rd_addr] : shadow_q[rd_addr];
    end

    always_ff @(posedge clk_reg) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            commit_done_q <= 1'b0;
            busy_q        <= 1'b0;
            wr_ready_q    <= 1'b1;
            err_range_q   <= 1'b0;
            rd_data_q     <= '0;
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            commit_done_q <= commit_done_d;
            busy_q        <= busy_d;
            wr_ready_q    <= wr_ready_d;
            err_range_q   <= err_range_d;
            rd_data_q     <= rd_data_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
        end
    end

    for (genvar m = 0; m < DEPTH; m++) begin : g_bus
        assign cmd_ch_dly[m*CMD_WIDTH +: CMD_WIDTH] = active_q[m];
    end

    assign wr_ready    = wr_ready_q;
    assign commit_done = commit_done_q;
    assign busy        = busy_q;
    assign err_range   = err_range_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_dly_cmd_table.sv
// Directed bench for dly_cmd_table with default parameters (HOLD_CYCLES = 16).
module tb_dly_cmd_table;

    logic          clk_reg = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [5:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          wr_ready;
    logic          commit;
    logic          commit_done;
    logic          busy;
    logic          rd_sel;
    logic [5:0]    rd_addr;
    logic [31:0]   rd_data;
    logic          err_range;
    logic          err_clr;
    logic [2047:0] cmd_ch_dly;

    int n_chk = 0;
    int n_err = 0;

    dly_cmd_table dut (
        .clk_reg     (clk_reg),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .commit      (commit),
        .commit_done (commit_done),
        .busy        (busy),
        .rd_sel      (rd_sel),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .err_range   (err_range),
        .err_clr     (err_clr),
        .cmd_ch_dly  (cmd_ch_dly)
    );

    always #5 clk_reg = ~clk_reg;

    task automatic tick();
        @(posedge clk_reg);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int first_seen;
        int done1;
        int done2;
        int ndone;
        int nbus;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
        rd_sel = 1'b0; rd_addr = '0; err_clr = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_bus_zero", {31'd0, cmd_ch_dly == '0}, 32'd1);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_commit_done", {31'd0, commit_done}, 32'd0);
        chk("rst_err", {31'd0, err_range}, 32'd0);
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 64; a++) begin
                rd_sel = s[0]; rd_addr = a[5:0];
                tick();
                chk("rst_readback", rd_data, 32'd0);
            end
        end

        // Basic publish
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = 32'd10;
        tick();
        wr_addr = 6'd63; wr_data = 32'd4095;
        tick();
        wr_en = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("pub_bus_before", cmd_ch_dly[31:0], 32'd0);
        chk("pub_busy", {31'd0, busy}, 32'd1);
        chk("pub_apply_wr_ready", {31'd0, wr_ready}, 32'd0);
        tick();
        chk("pub_bus_lo", cmd_ch_dly[31:0], 32'd10);
        chk("pub_bus_hi", cmd_ch_dly[2047:2016], 32'd4095);
        chk("pub_hold_wr_ready", {31'd0, wr_ready}, 32'd1);
        ndone = 0; done1 = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (commit_done) begin
                ndone++;
                if (done1 < 0) done1 = k;
            end
        end
        chk("pub_done_count", ndone, 32'd1);
        chk("pub_done_edge", done1, 32'd16);
        chk("pub_idle_busy", {31'd0, busy}, 32'd0);

        // Clamp and sticky error flag
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'd5000;
        tick();
        wr_en = 1'b0;
        chk("clamp_err_set", {31'd0, err_range}, 32'd1);
        rd_sel = 1'b0; rd_addr = 6'd5;
        tick();
        chk("clamp_rd", rd_data, 32'd4095);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr_alone", {31'd0, err_range}, 32'd0);
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 32'd4095;
        tick();
        chk("max_no_err", {31'd0, err_range}, 32'd0);
        err_clr = 1'b1; wr_addr = 6'd6; wr_data = 32'd4096;
        tick();
        err_clr = 1'b0; wr_en = 1'b0;
        chk("clr_vs_set", {31'd0, err_range}, 32'd1);
        wr_en = 1'b1; wr_addr = 6'd8; wr_data = 32'hFFFF_FFFF;
        tick();
        wr_en = 1'b0; rd_addr = 6'd6;
        tick();
        chk("clamp_4096_rd", rd_data, 32'd4095);
        rd_addr = 6'd8;
        tick();
        chk("clamp_unsigned_rd", rd_data, 32'd4095);

        // Hold / pending: one write and three commits during HOLD
        commit = 1'b1;
        tick();
        commit = 1'b0;
        first_seen = -1; done1 = -1; done2 = -1; ndone = 0;
        for (int k = 1; k <= 50; k++) begin
            wr_en = (k == 2);
            wr_addr = 6'd1;
            wr_data = 32'd7;
            commit = (k == 4) || (k == 6) || (k == 9);
            tick();
            if (cmd_ch_dly[63:32] == 32'd7 && first_seen < 0) first_seen = k;
            if (commit_done) begin
                ndone++;
                if (done1 < 0) done1 = k;
                else if (done2 < 0) done2 = k;
            end
            if (k == 1) chk("hp_first_bus_ch5", cmd_ch_dly[191:160], 32'd4095);
            if (k == 17) chk("hp_reapply_wr_ready", {31'd0, wr_ready}, 32'd0);
        end
        wr_en = 1'b0; commit = 1'b0;
        chk("hp_bus_update_edge", first_seen, 32'd18);
        chk("hp_done1_edge", done1, 32'd17);
        chk("hp_done2_edge", done2, 32'd34);
        chk("hp_done_count", ndone, 32'd2);
        chk("hp_idle_busy", {31'd0, busy}, 32'd0);

        // Write during APPLY is ignored
        commit = 1'b1;
        tick();
        commit = 1'b0; wr_en = 1'b1; wr_addr = 6'd2; wr_data = 32'd99;
        tick();
        wr_en = 1'b0; rd_sel = 1'b0; rd_addr = 6'd2;
        tick();
        chk("apply_write_ignored", rd_data, 32'd0);
        wait_idle();

        // Write and commit together in IDLE
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'd55; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        tick();
        chk("same_cycle_bus", cmd_ch_dly[127:96], 32'd55);
        rd_sel = 1'b1; rd_addr = 6'd3;
        tick();
        chk("same_cycle_active_rd", rd_data, 32'd55);
        wait_idle();

        // Reset mid-HOLD with pending set
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_bus_zero", {31'd0, cmd_ch_dly == '0}, 32'd1);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_wr_ready", {31'd0, wr_ready}, 32'd1);
        ndone = 0; nbus = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (commit_done) ndone++;
            if (cmd_ch_dly != '0 || busy) nbus++;
        end
        chk("mid_no_done", ndone, 32'd0);
        chk("mid_stays_idle", nbus, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
